// File: rtl/mpu_pkg.sv
// Shared FSM state encoding and reduce-mode constants for msg_process_unit.
package mpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_READ_WAIT  = 3'd2,
    ST_REDUCE     = 3'd3,
    ST_CHECK      = 3'd4,
    ST_WRITE      = 3'd5,
    ST_WRITE_WAIT = 3'd6
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_MAX  = 2'b01;
  localparam logic [1:0] MODE_MIN  = 2'b10;
  localparam logic [1:0] MODE_SUM  = 2'b11;

endpackage

// File: rtl/msg_process_unit_reduce_alu.sv
// Combinational reduction of an incoming value against a vertex's temp property.
module reduce_alu
  import mpu_pkg::*;
#(
  parameter int VPropWidth   = 32,
  parameter int EDegreeWidth = 32
) (
  input  logic [1:0]              mode,
  input  logic [VPropWidth-1:0]   new_val,
  input  logic [VPropWidth-1:0]   old_temp,
  input  logic [EDegreeWidth-1:0] degree,
  output logic                    active,
  output logic [VPropWidth-1:0]   result
);

  always_comb begin
    active = 1'b0;
    result = old_temp;
    case (mode)
      MODE_MAX: begin
        if (new_val > old_temp) begin
          active = 1'b1;
          result = new_val;
        end
      end
      MODE_MIN: begin
        if (new_val < old_temp) begin
          active = 1'b1;
          result = new_val;
        end
      end
      MODE_SUM: begin
        result = old_temp + new_val;
        active = (new_val != '0);
      end
      default: ;
    endcase
    // A vertex with no outgoing edges never propagates.
    if (degree == '0) active = 1'b0;
  end

endmodule

// File: rtl/msg_process_unit.sv
// Message queue + read-reduce-write engine feeding the message generator.
// Optional MPU_STATS_EN adds saturating pop/active counters.
module msg_process_unit
  import mpu_pkg::*;
#(
  parameter int VPropWidth   = 32,
  parameter int VPropStart   = 64,
  parameter int EIndexWidth  = 32,
  parameter int EDegreeWidth = 32,
  parameter int AddrWidth    = 33,
  parameter int DataWidth    = 256,
  parameter int UpdateWidth  = 65,
  parameter int FifoDepth    = 8
) (
  input  logic                                         clk,
  input  logic                                         resetn,
  input  logic [UpdateWidth-1:0]                       update,
  input  logic                                         update_ready,
  output logic                                         update_resp,
  input  logic [1:0]                                   control,
  output logic [AddrWidth-1:0]                         read_addr,
  output logic                                         start_rd,
  input  logic                                         end_rd,
  input  logic [DataWidth-1:0]                         read_data,
  output logic [AddrWidth-1:0]                         write_addr,
  output logic [DataWidth-1:0]                         write_data,
  output logic                                         start_wr,
  input  logic                                         end_wr,
  output logic [VPropWidth+EIndexWidth+EDegreeWidth:0] MGU_data,
  output logic                                         MGU_ready,
`ifdef MPU_STATS_EN
  input  logic                                         MGU_resp,
  output logic [31:0]                                  stat_msgs,
  output logic [31:0]                                  stat_active
`else
  input  logic                                         MGU_resp
`endif
);

  localparam int PtrW   = $clog2(FifoDepth);
  localparam int CntW   = PtrW + 1;
  localparam int EntryW = UpdateWidth + 2;

  logic [EntryW-1:0] fifo_mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count;
  logic              push, pop, full, empty;
  state_t            state;

  logic [UpdateWidth-1:0]  msg_p0;
  logic [1:0]              mode_p0;
  logic [DataWidth-1:0]    rd_word_p1;
  logic [VPropWidth-1:0]   result_p2;
  logic [EIndexWidth-1:0]  index_p2;
  logic [EDegreeWidth-1:0] degree_p2;
  logic                    active_p2;

  logic                    alu_active;
  logic [VPropWidth-1:0]   alu_result;
  logic [DataWidth-1:0]    merged_word;

  assign full  = (count == CntW'(FifoDepth));
  assign empty = (count == '0);
  // update_resp gating keeps a held update_ready from being accepted twice.
  assign push  = update_ready && !full && !update_resp;
  assign pop   = (state == ST_IDLE) && !empty && !MGU_ready;

  reduce_alu #(
    .VPropWidth  (VPropWidth),
    .EDegreeWidth(EDegreeWidth)
  ) u_reduce_alu (
    .mode    (mode_p0),
    .new_val (msg_p0[VPropWidth-1:0]),
    .old_temp(rd_word_p1[VPropStart+VPropWidth +: VPropWidth]),
    .degree  (rd_word_p1[0 +: EDegreeWidth]),
    .active  (alu_active),
    .result  (alu_result)
  );

  always_comb begin
    merged_word = rd_word_p1;
    merged_word[VPropStart +: VPropWidth]            = result_p2;
    merged_word[VPropStart+VPropWidth +: VPropWidth] = result_p2;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {control, update};
    // p0: message dequeued
    if (pop) {mode_p0, msg_p0} <= fifo_mem[rd_ptr];
    // p1: vertex word captured
    if (state == ST_READ_WAIT && end_rd) rd_word_p1 <= read_data;
    // p2: reduction result and edge fields registered
    if (state == ST_REDUCE) begin
      result_p2 <= alu_result;
      active_p2 <= alu_active;
      index_p2  <= rd_word_p1[EDegreeWidth +: EIndexWidth];
      degree_p2 <= rd_word_p1[0 +: EDegreeWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      update_resp <= 1'b0;
      start_rd    <= 1'b0;
      start_wr    <= 1'b0;
      MGU_ready   <= 1'b0;
      read_addr   <= '0;
      write_addr  <= '0;
      write_data  <= '0;
      MGU_data    <= '0;
`ifdef MPU_STATS_EN
      stat_msgs   <= '0;
      stat_active <= '0;
`endif
    end else begin
      update_resp <= push;
      start_rd    <= 1'b0;
      start_wr    <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: ;
      endcase
      if (MGU_ready && MGU_resp) begin
        MGU_ready <= 1'b0;
        MGU_data  <= '0;
      end
`ifdef MPU_STATS_EN
      if (pop && stat_msgs != '1) stat_msgs <= stat_msgs + 32'd1;
      if (state == ST_CHECK && active_p2 && stat_active != '1)
        stat_active <= stat_active + 32'd1;
`endif
      case (state)
        ST_IDLE: if (pop) state <= ST_READ;
        ST_READ: begin
          read_addr <= msg_p0[UpdateWidth-1 -: AddrWidth];
          start_rd  <= 1'b1;
          state     <= ST_READ_WAIT;
        end
        ST_READ_WAIT: if (end_rd) state <= ST_REDUCE;
        ST_REDUCE:    state <= ST_CHECK;
        ST_CHECK: begin
          if (active_p2) begin
            write_addr <= read_addr;
            write_data <= merged_word;
            MGU_data   <= {1'b0, result_p2, index_p2, degree_p2};
            MGU_ready  <= 1'b1;
            state      <= ST_WRITE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          start_wr <= 1'b1;
          state    <= ST_WRITE_WAIT;
        end
        ST_WRITE_WAIT: if (end_wr) state <= ST_IDLE;
        default:       state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_process_unit.sv
// Scoreboard bench for msg_process_unit: directed messages, memory/MGU responders, monitor.
module tb_msg_process_unit;

  localparam int AW = 33;
  localparam int DW = 256;
  localparam int UW = 65;
  localparam int MW = 97;
  localparam logic [127:0] OTH = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [UW-1:0] update = '0;
  logic          update_ready = 1'b0;
  logic          update_resp;
  logic [1:0]    control = 2'b00;
  logic [AW-1:0] read_addr;
  logic          start_rd;
  logic          end_rd = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          start_wr;
  logic          end_wr = 1'b0;
  logic [MW-1:0] MGU_data;
  logic          MGU_ready;
  logic          MGU_resp = 1'b0;

  always #5 clk = ~clk;

  msg_process_unit #(.FifoDepth(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .update      (update),
    .update_ready(update_ready),
    .update_resp (update_resp),
    .control     (control),
    .read_addr   (read_addr),
    .start_rd    (start_rd),
    .end_rd      (end_rd),
    .read_data   (read_data),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .start_wr    (start_wr),
    .end_wr      (end_wr),
    .MGU_data    (MGU_data),
    .MGU_ready   (MGU_ready),
    .MGU_resp    (MGU_resp)
  );

  logic [DW-1:0] mem [16];
  logic [AW-1:0] exp_waddr [$];
  logic [DW-1:0] exp_wdata [$];
  logic [MW-1:0] exp_mgu [$];
  int  total = 0;
  int  bad = 0;
  bit  hold_rd = 1'b0;
  bit  rd_pend = 1'b0;
  bit  wr_pend = 1'b0;
  int  mgu_delay = 1;
  logic [AW-1:0] rd_pend_addr = '0;

  function automatic logic [DW-1:0] mk(input logic [31:0] temp, input logic [31:0] p,
                                       input logic [31:0] idx, input logic [31:0] deg);
    return {OTH, temp, p, idx, deg};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_update_resp"}, DW'(update_resp), '0);
    check({tag, "_start_rd"},    DW'(start_rd),    '0);
    check({tag, "_start_wr"},    DW'(start_wr),    '0);
    check({tag, "_mgu_ready"},   DW'(MGU_ready),   '0);
    check({tag, "_read_addr"},   DW'(read_addr),   '0);
    check({tag, "_write_addr"},  DW'(write_addr),  '0);
    check({tag, "_write_data"},  write_data,       '0);
    check({tag, "_mgu_data"},    DW'(MGU_data),    '0);
  endtask

  task automatic expect_active(input logic [AW-1:0] a, input logic [31:0] res,
                               input logic [31:0] idx, input logic [31:0] deg);
    exp_waddr.push_back(a);
    exp_wdata.push_back(mk(res, res, idx, deg));
    exp_mgu.push_back({1'b0, res, idx, deg});
  endtask

  task automatic send(input logic [1:0] m, input logic [AW-1:0] a, input logic [31:0] v,
                      input int limit, output bit ok);
    @(negedge clk);
    control = m;
    update = {a, v};
    update_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (update_resp) begin
        ok = 1'b1;
        break;
      end
    end
    update_ready = 1'b0;
    if (ok) begin
      @(negedge clk);
      check("resp_pulse", DW'(update_resp), '0);
    end
  endtask

  task automatic wait_drain(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_waddr.size() == 0 && exp_mgu.size() == 0 && !MGU_ready && !rd_pend && !wr_pend) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", DW'(done), DW'(1));
    repeat (10) @(negedge clk);
  endtask

  // Memory read responder
  initial begin
    forever begin
      @(negedge clk);
      end_rd = 1'b0;
      if (start_rd) begin
        rd_pend = 1'b1;
        rd_pend_addr = read_addr;
      end else if (rd_pend && !hold_rd) begin
        read_data = mem[rd_pend_addr[3:0]];
        end_rd = 1'b1;
        rd_pend = 1'b0;
      end
    end
  end

  // Memory write responder
  initial begin
    forever begin
      @(negedge clk);
      end_wr = 1'b0;
      if (start_wr) wr_pend = 1'b1;
      else if (wr_pend) begin
        end_wr = 1'b1;
        wr_pend = 1'b0;
      end
    end
  end

  // MGU responder
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      MGU_resp = 1'b0;
      if (MGU_ready) begin
        cnt++;
        if (cnt >= mgu_delay) MGU_resp = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // Output monitor
  initial begin
    logic          prev = 1'b0;
    logic [MW-1:0] held = '0;
    forever begin
      @(negedge clk);
      if (start_wr) begin
        if (exp_waddr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h expected no write", write_addr);
        end else begin
          check("write_addr", DW'(write_addr), DW'(exp_waddr.pop_front()));
          check("write_data", write_data, exp_wdata.pop_front());
        end
      end
      if (MGU_ready && !prev) begin
        held = MGU_data;
        if (exp_mgu.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_mgu: got %0h expected no MGU_ready", MGU_data);
        end else begin
          check("mgu_data", DW'(MGU_data), DW'(exp_mgu.pop_front()));
        end
      end else if (MGU_ready && prev) begin
        check("mgu_stable", DW'(MGU_data), DW'(held));
      end
      if (!MGU_ready && prev) check("mgu_data_clear", DW'(MGU_data), '0);
      if (start_rd) check("no_pop_during_mgu", DW'(MGU_ready), '0);
      prev = MGU_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1]  = mk(10, 77, 32'h55, 3);
    mem[2]  = mk(10, 10, 32'h66, 3);
    mem[3]  = mk(32'hFFFF_FFFF, 5, 32'h77, 2);
    mem[4]  = mk(5, 5, 9, 1);
    mem[5]  = mk(5, 5, 9, 0);
    mem[6]  = mk(3, 3, 4, 4);
    mem[7]  = mk(0, 0, 32'hA, 2);
    mem[8]  = mk(100, 100, 32'hB, 6);
    mem[9]  = mk(1, 1, 1, 1);
    mem[10] = mk(10, 10, 32'hC, 1);

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // MIN active: 4 < 10
    expect_active(33'd1, 4, 32'h55, 3);
    send(2'b10, 33'd1, 4, 50, ok);
    check("send_min_active", DW'(ok), DW'(1));
    wait_drain(200);

    // MIN inactive: 12 >= 10
    send(2'b10, 33'd2, 12, 50, ok);
    check("send_min_inactive", DW'(ok), DW'(1));
    repeat (20) @(negedge clk);

    // SUM wraps: 0xFFFFFFFF + 2 = 1
    expect_active(33'd3, 1, 32'h77, 2);
    send(2'b11, 33'd3, 2, 50, ok);
    check("send_sum_wrap", DW'(ok), DW'(1));
    wait_drain(200);

    // MAX active, then MAX with degree 0, SUM of zero, mode none
    expect_active(33'd4, 7, 9, 1);
    send(2'b01, 33'd4, 7, 50, ok);
    wait_drain(200);
    send(2'b01, 33'd5, 7, 50, ok);
    send(2'b11, 33'd6, 0, 50, ok);
    send(2'b00, 33'd6, 99, 50, ok);
    repeat (40) @(negedge clk);

    // MGU held off 20 cycles with a second message queued behind it
    mgu_delay = 20;
    expect_active(33'd7, 32'h1234, 32'hA, 2);
    expect_active(33'd8, 50, 32'hB, 6);
    send(2'b01, 33'd7, 32'h1234, 50, ok);
    send(2'b10, 33'd8, 50, 50, ok);
    check("send_second_queued", DW'(ok), DW'(1));
    wait_drain(400);
    mgu_delay = 1;

    // Queue full while the read is stalled: 1 in flight + 8 queued, 10th blocked
    hold_rd = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(2'b00, 33'd9, 32'(i), 20, ok);
      check("fill_accept", DW'(ok), DW'(1));
    end
    send(2'b00, 33'd9, 32'd9, 20, ok);
    check("full_block", DW'(ok), DW'(0));
    hold_rd = 1'b0;
    send(2'b00, 33'd9, 32'd9, 100, ok);
    check("accept_after_pop", DW'(ok), DW'(1));
    repeat (150) @(negedge clk);

    // Reset while waiting for read data abandons the transaction
    hold_rd = 1'b1;
    send(2'b10, 33'd10, 1, 50, ok);
    for (int i = 0; i < 50 && !rd_pend; i++) @(negedge clk);
    check("reached_read_wait", DW'(rd_pend), DW'(1));
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("mid_reset");
    resetn = 1'b1;
    hold_rd = 1'b0;
    repeat (30) @(negedge clk);
    check_zero("post_reset");

    check("leftover_writes", DW'(exp_waddr.size()), '0);
    check("leftover_mgu", DW'(exp_mgu.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
